// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller.
// Holds the controller state encoding and the default operand widths.
package mod_exp_ctrl_pkg;

    localparam int unsigned DEF_NBITS = 4096;
    localparam int unsigned DEF_EBITS = 4096;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_SQR_REQ  = 3'd2,
        ST_SQR_WAIT = 3'd3,
        ST_MUL_REQ  = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/response bus between the exponentiation controller and an
// external modular multiplier.
//   mm_enable_p : single-cycle request
//   mm_a, mm_b  : operands, held until mm_done_p is sampled
//   mm_m        : modulus
//   mm_y        : product (a*b mod m), valid with mm_done_p
//   mm_done_p   : single-cycle completion pulse
// master = controller side, slave = multiplier side.
interface mod_exp_ctrl_if
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS
);
    logic             mm_enable_p;
    logic [NBITS-1:0] mm_a;
    logic [NBITS-1:0] mm_b;
    logic [NBITS-1:0] mm_m;
    logic [NBITS-1:0] mm_y;
    logic             mm_done_p;

    modport master (
        output mm_enable_p, mm_a, mm_b, mm_m,
        input  mm_y, mm_done_p
    );

    modport slave (
        input  mm_enable_p, mm_a, mm_b, mm_m,
        output mm_y, mm_done_p
    );
endinterface

// File: rtl/mod_exp_scan.sv
// Exponent shift register with remaining-bit counter.
//   i_load  : capture i_e, counter = EBITS
//   i_shift : shift exponent left by one, counter - 1 (consumes a bit)
//   o_msb   : current exponent bit (MSB of the shift register)
//   o_more  : at least one bit remains after consuming the current one
module mod_exp_scan
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned EBITS = DEF_EBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [EBITS-1:0] i_e,
    input  logic             i_shift,
    output logic             o_msb,
    output logic             o_more
);
    localparam int unsigned CW = $clog2(EBITS + 1);

    logic [EBITS-1:0] r_exp;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_exp <= i_e;
            r_cnt <= CW'(EBITS);
        end else if (i_shift) begin
            r_exp <= {r_exp[EBITS-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_msb  = r_exp[EBITS-1];
    assign o_more = (r_cnt > CW'(1));

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary modular exponentiation controller: y = x^e mod m,
// using an external modular multiplier over mod_exp_ctrl_if.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_p     : single-cycle request, samples x, e, m (ignored while busy)
//   x, e, m     : base, exponent, modulus
//   y           : result, held until the next completion
//   busy        : high in every state except IDLE
//   done_p      : single-cycle completion pulse
//   mm          : multiplier initiator bus (master)
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned EBITS = DEF_EBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_p,
    input  logic [NBITS-1:0]   x,
    input  logic [EBITS-1:0]   e,
    input  logic [NBITS-1:0]   m,
    output logic [NBITS-1:0]   y,
    output logic               busy,
    output logic               done_p,
    mod_exp_ctrl_if.master     mm
);
    state_t           r_state, w_state_next;
    logic [NBITS-1:0] r_r, w_r_next;
    logic [NBITS-1:0] r_x, r_m, r_y;
    logic             w_load, w_shift, w_msb, w_more;
    logic             w_in_op, w_in_mul;

    mod_exp_scan #(
        .EBITS (EBITS)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_e     (e),
        .i_shift (w_shift),
        .o_msb   (w_msb),
        .o_more  (w_more)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_r     <= '0;
            r_x     <= '0;
            r_m     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_r     <= w_r_next;
            if (w_load) begin
                r_x <= x;
                r_m <= m;
            end
            // y takes the final accumulator value on entry to DONE so it
            // is already valid while done_p is high.
            if (w_state_next == ST_DONE) begin
                r_y <= w_r_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_r_next     = r_r;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_p) begin
                    w_load = 1'b1;
                    if (e == '0) begin
                        w_r_next     = NBITS'(1);
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // Shifts past leading zeros; the leading one is consumed
                // by the same shift that brings the next bit into the MSB.
                w_shift = 1'b1;
                if (w_msb) begin
                    w_r_next     = r_x;
                    w_state_next = w_more ? ST_SQR_REQ : ST_DONE;
                end
            end
            ST_SQR_REQ: w_state_next = ST_SQR_WAIT;
            ST_SQR_WAIT: begin
                if (mm.mm_done_p) begin
                    w_r_next = mm.mm_y;
                    if (w_msb) begin
                        w_state_next = ST_MUL_REQ;
                    end else begin
                        w_shift      = 1'b1;
                        w_state_next = w_more ? ST_SQR_REQ : ST_DONE;
                    end
                end
            end
            ST_MUL_REQ: w_state_next = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mm.mm_done_p) begin
                    w_r_next     = mm.mm_y;
                    w_shift      = 1'b1;
                    w_state_next = w_more ? ST_SQR_REQ : ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operands come straight from registers that only change on the
    // mm_done_p edge, so they stay stable across each wait.
    assign w_in_op  = (r_state == ST_SQR_REQ) || (r_state == ST_SQR_WAIT) ||
                      (r_state == ST_MUL_REQ) || (r_state == ST_MUL_WAIT);
    assign w_in_mul = (r_state == ST_MUL_REQ) || (r_state == ST_MUL_WAIT);

    assign mm.mm_enable_p = (r_state == ST_SQR_REQ) || (r_state == ST_MUL_REQ);
    assign mm.mm_a        = w_in_op ? r_r : '0;
    assign mm.mm_b        = !w_in_op ? '0 : (w_in_mul ? r_x : r_r);
    assign mm.mm_m        = r_m;

    assign y      = r_y;
    assign busy   = (r_state != ST_IDLE);
    assign done_p = (r_state == ST_DONE);

endmodule
